// File: rtl/mmu_ctx_sched_pkg.sv
// ============================================================================
// Module : mmu_pkg
// Brief  : Shared scheduler state encoding, mode constants and defaults.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_BASE  = 3'd2,
        ST_ENTER = 3'd3,
        ST_RUN   = 3'd4,
        ST_EXIT  = 3'd5
    } state_e;

    localparam logic KERNEL_MODE = 1'b0;
    localparam logic USER_MODE   = 1'b1;

    localparam int DEF_MAX_PID = 10;

endpackage

`default_nettype wire

// File: rtl/mmu_ctx_sched_if.sv
// ============================================================================
// Module : mmu_ctx_sched_if
// Brief  : Dispatch request bus plus MMU configuration port.
//          Optional pid_err signal exists under MMU_CTX_PID_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmu_ctx_sched_if #(
    parameter int PID_W   = 4,
    parameter int QUANT_W = 16
);
    logic               req;
    logic [PID_W-1:0]   pid;
    logic [31:0]        base;
    logic               load_base;
    logic [QUANT_W-1:0] quantum;
    logic               trap;
    logic               busy;
    logic               done;
    logic               irq_preempt;
    logic               we_sel;
    logic [31:0]        sel;
    logic               we_addr;
    logic [31:0]        offset;
    logic               userMode;
    logic               kernelMode;
`ifdef MMU_CTX_PID_CHECK_EN
    logic               pid_err;
`endif

    modport master (
        output req, pid, base, load_base, quantum, trap,
        input  busy, done, irq_preempt, we_sel, sel, we_addr, offset,
               userMode, kernelMode
`ifdef MMU_CTX_PID_CHECK_EN
        , input pid_err
`endif
    );

    modport slave (
        input  req, pid, base, load_base, quantum, trap,
        output busy, done, irq_preempt, we_sel, sel, we_addr, offset,
               userMode, kernelMode
`ifdef MMU_CTX_PID_CHECK_EN
        , output pid_err
`endif
    );

endinterface

`default_nettype wire

// File: rtl/mmu_ctx_sched_quantum_timer.sv
// ============================================================================
// Module : quantum_timer
// Brief  : Loadable down-counter that saturates at zero and emits a
//          registered one-cycle pulse on the 1 -> 0 step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module quantum_timer #(
    parameter int QUANT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [QUANT_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               expire_o
);

    logic [QUANT_W-1:0] count_q, count_d;
    logic               expire_q, expire_d;

    always_comb begin
        count_d  = count_q;
        expire_d = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d  = count_q - QUANT_W'(1);
            expire_d = (count_q == QUANT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

`default_nettype wire

// File: rtl/mmu_ctx_sched.sv
// ============================================================================
// Module : mmu_ctx_sched
// Brief  : Context-switch sequencer programming the MMU, then time-slicing
//          the dispatched process. Optional range check: MMU_CTX_PID_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_ctx_sched
    import mmu_pkg::*;
#(
    parameter int PID_W   = 4,
    parameter int MAX_PID = DEF_MAX_PID,
    parameter int QUANT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    mmu_ctx_sched_if.slave bus_io
);

    state_e             state_q;
    logic [31:0]        base_q;
    logic               load_base_q;
    logic [QUANT_W-1:0] quantum_q;
    logic               busy_q;
    logic               done_q;
    logic               we_sel_q;
    logic [31:0]        sel_q;
    logic               we_addr_q;
    logic [31:0]        offset_q;
    logic               user_q;
    logic               kernel_q;

    logic               pid_ok;
    logic               tmr_load;
    logic               tmr_en;
    logic               tmr_expire;

`ifdef MMU_CTX_PID_CHECK_EN
    logic pid_err_q;

    assign pid_ok = (int'(bus_io.pid) <= MAX_PID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_err_q <= 1'b0;
        end else begin
            pid_err_q <= (state_q == ST_IDLE) && bus_io.req && !pid_ok;
        end
    end

    assign bus_io.pid_err = pid_err_q;
`else
    assign pid_ok = 1'b1;
`endif

    // Trap suppresses the decrement so a simultaneous expiry never pulses irq.
    assign tmr_load = (state_q == ST_ENTER);
    assign tmr_en   = (state_q == ST_RUN) && !bus_io.trap && (quantum_q != '0);

    quantum_timer #(
        .QUANT_W (QUANT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (quantum_q),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    // Strobes are registered on the transition into the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            load_base_q <= 1'b0;
            quantum_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_sel_q    <= 1'b0;
            sel_q       <= '0;
            we_addr_q   <= 1'b0;
            offset_q    <= '0;
            user_q      <= 1'b0;
            kernel_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            we_sel_q  <= 1'b0;
            we_addr_q <= 1'b0;
            user_q    <= 1'b0;
            kernel_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_io.req && pid_ok) begin
                        base_q      <= bus_io.base;
                        load_base_q <= bus_io.load_base;
                        quantum_q   <= bus_io.quantum;
                        sel_q       <= 32'(bus_io.pid);
                        we_sel_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (load_base_q) begin
                        offset_q  <= base_q;
                        we_addr_q <= 1'b1;
                        state_q   <= ST_BASE;
                    end else begin
                        user_q  <= 1'b1;
                        state_q <= ST_ENTER;
                    end
                end
                ST_BASE: begin
                    user_q  <= 1'b1;
                    state_q <= ST_ENTER;
                end
                ST_ENTER: begin
                    done_q  <= 1'b1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus_io.trap || tmr_expire) begin
                        kernel_q <= 1'b1;
                        state_q  <= ST_EXIT;
                    end
                end
                ST_EXIT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_io.busy        = busy_q;
    assign bus_io.done        = done_q;
    assign bus_io.irq_preempt = tmr_expire;
    assign bus_io.we_sel      = we_sel_q;
    assign bus_io.sel         = sel_q;
    assign bus_io.we_addr     = we_addr_q;
    assign bus_io.offset      = offset_q;
    assign bus_io.userMode    = user_q;
    assign bus_io.kernelMode  = kernel_q;

endmodule

`default_nettype wire
